// File: rtl/output_evaluator.sv
// Per-case output evaluator: accumulates output mismatches and absolute activation error
// over each block cycle, then publishes case results and running accuracy statistics.
module output_evaluator #(
   parameter int cpc       = 18,
   parameter int P         = 1,
   parameter int width     = 32,
   parameter int frac_bits = 21,
   parameter int W         = 100,
   parameter int max_cases = 100000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [$clog2(cpc)-1:0]     cycle_index,
   input  logic [P-1:0]               a_out,
   input  logic [P-1:0]               y_out,
   input  logic [P*width-1:0]         actL,
   input  logic                       clear,
   output logic                       case_done,
   output logic                       tc_error,
   output logic [width+7:0]           err_sum,
   output logic [31:0]                num_train,
   output logic [31:0]                total_error,
   output logic [$clog2(W+1)-1:0]     recent,
   output logic                       done
);

   localparam int CIW = $clog2(cpc);
   localparam int RW  = $clog2(W+1);
   localparam int EW  = width + 8;
   localparam int LW  = width + 1;
   // Wide enough to hold accumulator plus one clock of lane errors before saturating.
   localparam int SW  = EW + $clog2(P+1) + 1;

   localparam logic [LW-1:0]  ONE       = LW'(1) << frac_bits;
   localparam logic [CIW-1:0] CI_FIRST  = CIW'(2);
   localparam logic [CIW-1:0] CI_LAST   = CIW'(cpc - 1);
   localparam logic [31:0]    MAX_CASES = 32'(max_cases);

   logic            r_case_done;
   logic            r_tc_error;
   logic [EW-1:0]   r_err_sum;
   logic [31:0]     r_num_train;
   logic [31:0]     r_total_error;
   logic [RW-1:0]   r_recent;
   logic            r_done;
   logic [W-1:0]    r_win;
   logic            r_acc_mis;
   logic [EW-1:0]   r_acc_sum;

   logic [LW-1:0]   w_lane_err [P];
   logic [SW-1:0]   w_step_sum;
   logic [SW-1:0]   w_sum_full;
   logic [EW-1:0]   w_sum_sat;
   logic            w_eval;
   logic            w_final;
   logic            w_case_mis;
   logic            w_correct;
   logic [31:0]     w_num_inc;
   logic [31:0]     w_tot_inc;
   logic [W-1:0]    w_win_next;
   logic [RW-1:0]   w_recent_next;

   for (genvar g = 0; g < P; g++) begin : g_lane
      logic [LW-1:0] w_raw;
      logic [LW-1:0] w_clamp;
      assign w_raw         = {1'b0, actL[g*width +: width]};
      assign w_clamp       = (w_raw > ONE) ? ONE : w_raw;
      assign w_lane_err[g] = y_out[g] ? (ONE - w_clamp) : w_clamp;
   end

   always_comb begin
      w_step_sum = '0;
      for (int i = 0; i < P; i++) begin
         w_step_sum = w_step_sum + SW'(w_lane_err[i]);
      end
   end

   assign w_eval        = (cycle_index >= CI_FIRST) && !r_done;
   assign w_final       = (cycle_index == CI_LAST) && !r_done;
   assign w_case_mis    = r_acc_mis | (a_out != y_out);
   assign w_correct     = ~w_case_mis;
   assign w_sum_full    = SW'(r_acc_sum) + w_step_sum;
   assign w_sum_sat     = (|w_sum_full[SW-1:EW]) ? '1 : w_sum_full[EW-1:0];
   assign w_num_inc     = (&r_num_train) ? r_num_train : r_num_train + 32'd1;
   assign w_tot_inc     = (&r_total_error) ? r_total_error : r_total_error + 32'd1;
   // Oldest flag falls off the top; works for W==1 as well.
   assign w_win_next    = W'({r_win, w_correct});
   assign w_recent_next = r_recent + RW'(w_correct) - RW'(r_win[W-1]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_case_done   <= 1'b0;
         r_tc_error    <= 1'b0;
         r_err_sum     <= '0;
         r_num_train   <= '0;
         r_total_error <= '0;
         r_recent      <= '0;
         r_done        <= 1'b0;
         r_win         <= '0;
         r_acc_mis     <= 1'b0;
         r_acc_sum     <= '0;
      end else if (clear) begin
         r_case_done   <= 1'b0;
         r_tc_error    <= 1'b0;
         r_err_sum     <= '0;
         r_num_train   <= '0;
         r_total_error <= '0;
         r_recent      <= '0;
         r_done        <= 1'b0;
         r_win         <= '0;
         r_acc_mis     <= 1'b0;
         r_acc_sum     <= '0;
      end else begin
         r_case_done <= w_final;
         if (w_final) begin
            r_tc_error  <= w_case_mis;
            r_err_sum   <= w_sum_sat;
            r_acc_mis   <= 1'b0;
            r_acc_sum   <= '0;
            r_num_train <= w_num_inc;
            if (w_case_mis) begin
               r_total_error <= w_tot_inc;
            end
            r_win    <= w_win_next;
            r_recent <= w_recent_next;
            if (w_num_inc == MAX_CASES) begin
               r_done <= 1'b1;
            end
         end else if (w_eval) begin
            r_acc_mis <= w_case_mis;
            r_acc_sum <= w_sum_sat;
         end
      end
   end

   assign case_done   = r_case_done;
   assign tc_error    = r_tc_error;
   assign err_sum     = r_err_sum;
   assign num_train   = r_num_train;
   assign total_error = r_total_error;
   assign recent      = r_recent;
   assign done        = r_done;

endmodule

// File: tb/tb_output_evaluator.sv
// Directed bench for output_evaluator: one default instance and one with max_cases=3,
// both driven by the same stimulus.
module tb_output_evaluator;

   logic        clk;
   logic        reset;
   logic [4:0]  cycle_index;
   logic        a_out;
   logic        y_out;
   logic [31:0] actL;
   logic        clear;

   logic        d_case_done, d_tc, d_done;
   logic [39:0] d_err;
   logic [31:0] d_num, d_tot;
   logic [6:0]  d_recent;

   logic        m_case_done, m_tc, m_done;
   logic [39:0] m_err;
   logic [31:0] m_num, m_tot;
   logic [6:0]  m_recent;

   int n_checks = 0;
   int n_fail   = 0;

   output_evaluator dut (
      .clk(clk), .reset(reset), .cycle_index(cycle_index), .a_out(a_out), .y_out(y_out),
      .actL(actL), .clear(clear), .case_done(d_case_done), .tc_error(d_tc), .err_sum(d_err),
      .num_train(d_num), .total_error(d_tot), .recent(d_recent), .done(d_done)
   );

   output_evaluator #(.max_cases(3)) dut_mc (
      .clk(clk), .reset(reset), .cycle_index(cycle_index), .a_out(a_out), .y_out(y_out),
      .actL(actL), .clear(clear), .case_done(m_case_done), .tc_error(m_tc), .err_sum(m_err),
      .num_train(m_num), .total_error(m_tot), .recent(m_recent), .done(m_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int ci, input logic mis, input logic yv, input logic [31:0] act,
                        input logic clr);
      @(negedge clk);
      cycle_index = 5'(ci);
      y_out       = yv;
      a_out       = mis ? ~yv : yv;
      actL        = act;
      clear       = clr;
   endtask

   // Drives cycle_index first..17, then samples just after the finalize edge.
   task automatic run_case(input int first, input int mis_ci, input logic yv,
                           input logic [31:0] act, input int clr_ci);
      for (int ci = first; ci < 18; ci++) begin
         drive(ci, ci == mis_ci, yv, act, ci == clr_ci);
      end
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic idle_clk();
      drive(0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic hard_reset();
      @(negedge clk);
      reset = 1'b0;
      cycle_index = 5'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      clear = 1'b0;
      cycle_index = 5'd0;
      a_out = 1'b0;
      y_out = 1'b0;
      actL = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_num", 64'(d_num), 64'd0);
      chk("rst_recent", 64'(d_recent), 64'd0);
      chk("rst_done", 64'(d_done), 64'd0);
      reset = 1'b1;

      // Perfect case
      run_case(0, -1, 1'b1, 32'h200000, -1);
      chk("perf_pulse", 64'(d_case_done), 64'd1);
      chk("perf_tc", 64'(d_tc), 64'd0);
      chk("perf_err", 64'(d_err), 64'd0);
      chk("perf_num", 64'(d_num), 64'd1);
      chk("perf_tot", 64'(d_tot), 64'd0);
      chk("perf_recent", 64'(d_recent), 64'd1);
      idle_clk();
      chk("pulse_one_clk", 64'(d_case_done), 64'd0);

      // Asynchronous reset mid-case, away from any clock edge
      for (int ci = 0; ci <= 8; ci++) drive(ci, 1'b0, 1'b1, 32'h200000, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("async_num", 64'(d_num), 64'd0);
      chk("async_recent", 64'(d_recent), 64'd0);
      chk("async_mc_num", 64'(m_num), 64'd0);
      #1 reset = 1'b1;

      // Remainder of the interrupted case finalizes as a partial case
      run_case(9, 12, 1'b1, 32'h200000, -1);
      chk("part_pulse", 64'(d_case_done), 64'd1);
      chk("part_tc", 64'(d_tc), 64'd1);
      chk("part_num", 64'(d_num), 64'd1);
      chk("part_tot", 64'(d_tot), 64'd1);
      chk("part_recent", 64'(d_recent), 64'd0);

      // Single mismatch at cycle_index 5
      run_case(0, 5, 1'b0, 32'h0, -1);
      chk("mis_tc", 64'(d_tc), 64'd1);
      chk("mis_err", 64'(d_err), 64'd0);
      chk("mis_num", 64'(d_num), 64'd2);
      chk("mis_tot", 64'(d_tot), 64'd2);
      chk("mis_recent", 64'(d_recent), 64'd0);

      // Error sums, including an over-range activation clamped to 2^21
      hard_reset();
      run_case(0, -1, 1'b0, 32'h100000, -1);
      chk("half_err", 64'(d_err), 64'h1000000);
      chk("half_tc", 64'(d_tc), 64'd0);
      chk("half_recent", 64'(d_recent), 64'd1);
      run_case(0, -1, 1'b0, 32'hFFFFFFFF, -1);
      chk("clamp_err", 64'(d_err), 64'h2000000);
      chk("clamp_num", 64'(d_num), 64'd2);
      run_case(0, -1, 1'b1, 32'h300000, -1);
      chk("clamp_y1_err", 64'(d_err), 64'd0);

      // Window of 100 recent results
      hard_reset();
      for (int k = 0; k < 100; k++) run_case(0, -1, 1'b1, 32'h200000, -1);
      chk("win100_recent", 64'(d_recent), 64'd100);
      run_case(0, -1, 1'b1, 32'h200000, -1);
      chk("win101_recent", 64'(d_recent), 64'd100);
      chk("win101_num", 64'(d_num), 64'd101);
      run_case(0, 5, 1'b1, 32'h200000, -1);
      chk("win102_recent", 64'(d_recent), 64'd99);
      chk("win102_tot", 64'(d_tot), 64'd1);

      // max_cases = 3 on dut_mc
      hard_reset();
      run_case(0, -1, 1'b1, 32'h200000, -1);
      run_case(0, -1, 1'b1, 32'h200000, -1);
      chk("mc2_done", 64'(m_done), 64'd0);
      run_case(0, -1, 1'b1, 32'h200000, -1);
      chk("mc3_pulse", 64'(m_case_done), 64'd1);
      chk("mc3_done", 64'(m_done), 64'd1);
      chk("mc3_num", 64'(m_num), 64'd3);
      run_case(0, 5, 1'b1, 32'h200000, -1);
      chk("mc4_pulse", 64'(m_case_done), 64'd0);
      chk("mc4_num", 64'(m_num), 64'd3);
      chk("mc4_tot", 64'(m_tot), 64'd0);
      chk("mc4_recent", 64'(m_recent), 64'd3);
      chk("mc4_main_num", 64'(d_num), 64'd4);
      chk("mc4_main_tc", 64'(d_tc), 64'd1);

      // Clear on a finalize clock wins over the finalize
      run_case(0, 5, 1'b1, 32'h200000, 17);
      chk("clr_mc_pulse", 64'(m_case_done), 64'd0);
      chk("clr_mc_done", 64'(m_done), 64'd0);
      chk("clr_mc_num", 64'(m_num), 64'd0);
      chk("clr_mc_recent", 64'(m_recent), 64'd0);
      chk("clr_main_pulse", 64'(d_case_done), 64'd0);
      chk("clr_main_tc", 64'(d_tc), 64'd0);
      chk("clr_main_tot", 64'(d_tot), 64'd0);
      chk("clr_main_num", 64'(d_num), 64'd0);

      run_case(0, -1, 1'b1, 32'h200000, -1);
      chk("post_clr_pulse", 64'(m_case_done), 64'd1);
      chk("post_clr_num", 64'(m_num), 64'd1);
      chk("post_clr_tc", 64'(m_tc), 64'd0);
      chk("post_clr_done", 64'(m_done), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
